adc_iodelay_align_ctrl: RTL

Automatic-calibration controller for one ADC receiver lane (I or Q). Sweeps the IDELAY tap range, finds the widest stable data eye, parks the tap at the eye centre, then issues ISERDES bitslips until the deserialized word equals the ADC training pattern. Drives the automatic side of the manual/automatic calibration mux; one instance per lane, all signals in the `clk_i` domain.

---
 rtl/adc_align_pkg.sv | 27 ++
 rtl/iodelay_eye_tracker.sv | 59 +++++
 rtl/adc_iodelay_align_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_align_pkg.sv
// Shared types and constants for the ADC lane IDELAY/bitslip alignment controller.
package adc_align_pkg;

    localparam int TAP_W    = 5;
    localparam int NUM_TAPS = 32;

    localparam logic [1:0] FAIL_NONE     = 2'd0;
    localparam logic [1:0] FAIL_EYE      = 2'd1;
    localparam logic [1:0] FAIL_ALIGN    = 2'd2;
    localparam logic [1:0] FAIL_READBACK = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_NEXT,
        ST_CENTER,
        ST_CSETTLE,
        ST_SLIP_CHK,
        ST_SLIP,
        ST_SLIP_SETTLE,
        ST_DONE,
        ST_FAIL
    } align_state_t;

endpackage

// File: rtl/iodelay_eye_tracker.sv
// Tracks the current and best run of stable taps during a sweep and
// derives the centre tap of the best (earliest on ties) window.
module iodelay_eye_tracker
    import adc_align_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic             i_stable,
    input  logic [TAP_W-1:0] i_tap,
    output logic [TAP_W-1:0] o_best_start,
    output logic [TAP_W:0]   o_best_len,
    output logic [TAP_W-1:0] o_centre
);

    logic [TAP_W-1:0] r_cur_start;
    logic [TAP_W:0]   r_cur_len;
    logic [TAP_W-1:0] r_best_start;
    logic [TAP_W:0]   r_best_len;

    logic [TAP_W-1:0] w_run_start;
    logic [TAP_W:0]   w_run_len;

    assign w_run_start = (r_cur_len == '0) ? i_tap : r_cur_start;
    assign w_run_len   = r_cur_len + (TAP_W+1)'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (i_clear) begin
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (i_step) begin
            if (i_stable) begin
                r_cur_start <= w_run_start;
                r_cur_len   <= w_run_len;
                // Strictly greater: an equal-width later window never displaces the first.
                if (w_run_len > r_best_len) begin
                    r_best_start <= w_run_start;
                    r_best_len   <= w_run_len;
                end
            end else begin
                r_cur_len <= '0;
            end
        end
    end

    assign o_best_start = r_best_start;
    assign o_best_len   = r_best_len;
    // start + (len-1)/2 stays within 0..31 because start + len <= 32.
    assign o_centre     = r_best_start + TAP_W'((r_best_len - (TAP_W+1)'(1)) >> 1);

endmodule

// File: rtl/adc_iodelay_align_ctrl.sv
// Per-lane ADC calibration: sweep IDELAY taps for the widest stable eye,
// park at its centre, then bitslip until the training word is seen.
module adc_iodelay_align_ctrl
    import adc_align_pkg::*;
#(
    parameter logic [7:0] TRAIN_PATTERN = 8'hA5,
    parameter int          SETTLE_CYC    = 8,
    parameter int          CHECK_CYC     = 16,
    parameter int          MIN_EYE       = 4,
    parameter int          MAX_BITSLIP   = 7
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [7:0]       data_i,
    input  logic [TAP_W-1:0] dl_cnt_val_i,
    output logic             dl_ce_o,
    output logic             dl_in_o,
    output logic [TAP_W-1:0] dl_cnt_in_o,
    output logic             dl_load_val_o,
    output logic             bitslip_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [1:0]       fail_code_o,
    output logic [TAP_W-1:0] tap_o,
    output logic [TAP_W:0]   eye_width_o
);

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]       CHECK_LAST  = 8'(CHECK_CYC - 1);
    localparam logic [7:0]       SLIP_MAX    = 8'(MAX_BITSLIP);
    localparam logic [TAP_W:0]   EYE_MIN     = (TAP_W+1)'(MIN_EYE);
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);

    align_state_t r_state;
    align_state_t w_state_nxt;

    logic [7:0]       r_cnt;
    logic [7:0]       r_slip_cnt;
    logic [TAP_W-1:0] r_tap;
    logic [TAP_W-1:0] r_tap_out;
    logic             r_centering;
    logic             r_stable;
    logic             r_match;
    logic [7:0]       r_first_word;
    logic [1:0]       r_fail_code;

    logic [1:0]       w_fail_code_nxt;
    logic             w_start_acc;
    logic             w_settle_last;
    logic             w_check_last;
    logic             w_readback_ok;
    logic             w_word_ok;
    logic [TAP_W-1:0] w_best_start_unused;
    logic [TAP_W:0]   w_best_len;
    logic [TAP_W-1:0] w_centre;

    assign w_start_acc   = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                       (r_state == ST_FAIL));
    assign w_settle_last = (r_cnt == SETTLE_LAST);
    assign w_check_last  = (r_cnt == CHECK_LAST);
    assign w_readback_ok = (dl_cnt_val_i == r_tap);
    assign w_word_ok     = (data_i == TRAIN_PATTERN);

    iodelay_eye_tracker u_eye (
        .i_clk        (clk_i),
        .i_rst_n      (rst_n_i),
        .i_clear      (w_start_acc),
        .i_step       (r_state == ST_NEXT),
        .i_stable     (r_stable),
        .i_tap        (r_tap),
        .o_best_start (w_best_start_unused),
        .o_best_len   (w_best_len),
        .o_centre     (w_centre)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_fail_code_nxt = r_fail_code;
        dl_load_val_o   = 1'b0;
        bitslip_o       = 1'b0;
        busy_o          = 1'b1;
        done_o          = 1'b0;
        fail_o          = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                busy_o = 1'b0;
                done_o = (r_state == ST_DONE);
                fail_o = (r_state == ST_FAIL);
                if (w_start_acc) begin
                    w_state_nxt     = ST_LOAD;
                    w_fail_code_nxt = FAIL_NONE;
                end
            end
            ST_LOAD: begin
                dl_load_val_o = 1'b1;
                w_state_nxt   = r_centering ? ST_CSETTLE : ST_SETTLE;
            end
            ST_SETTLE, ST_CSETTLE: begin
                if (w_settle_last) begin
                    if (!w_readback_ok) begin
                        w_state_nxt     = ST_FAIL;
                        w_fail_code_nxt = FAIL_READBACK;
                    end else begin
                        w_state_nxt = (r_state == ST_CSETTLE) ? ST_SLIP_CHK : ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (w_check_last) w_state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                w_state_nxt = (r_tap == LAST_TAP) ? ST_CENTER : ST_LOAD;
            end
            ST_CENTER: begin
                if (w_best_len < EYE_MIN) begin
                    w_state_nxt     = ST_FAIL;
                    w_fail_code_nxt = FAIL_EYE;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_SLIP_CHK: begin
                if (w_check_last) begin
                    if (r_match && w_word_ok) begin
                        w_state_nxt = ST_DONE;
                    end else if (r_slip_cnt == SLIP_MAX) begin
                        w_state_nxt     = ST_FAIL;
                        w_fail_code_nxt = FAIL_ALIGN;
                    end else begin
                        w_state_nxt = ST_SLIP;
                    end
                end
            end
            ST_SLIP: begin
                bitslip_o   = 1'b1;
                w_state_nxt = ST_SLIP_SETTLE;
            end
            ST_SLIP_SETTLE: begin
                if (w_settle_last) w_state_nxt = ST_SLIP_CHK;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_slip_cnt  <= '0;
            r_tap       <= '0;
            r_tap_out   <= '0;
            r_centering <= 1'b0;
            r_stable    <= 1'b1;
            r_match     <= 1'b1;
            r_fail_code <= FAIL_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_fail_code <= w_fail_code_nxt;
            // Every state entry restarts the shared settle/check counter.
            r_cnt       <= (w_state_nxt != r_state) ? 8'd0 : r_cnt + 8'd1;

            if (w_start_acc) begin
                r_tap       <= '0;
                r_tap_out   <= '0;
                r_slip_cnt  <= '0;
                r_centering <= 1'b0;
            end

            case (r_state)
                ST_NEXT:   if (r_tap != LAST_TAP) r_tap <= r_tap + TAP_W'(1);
                ST_CENTER: begin
                    r_tap       <= w_centre;
                    r_centering <= 1'b1;
                end
                ST_SLIP:   r_slip_cnt <= r_slip_cnt + 8'd1;
                default:   ;
            endcase

            if (r_state == ST_LOAD)
                r_stable <= 1'b1;
            else if (r_state == ST_CHECK && r_cnt != 8'd0 && data_i != r_first_word)
                r_stable <= 1'b0;

            r_match <= (r_state == ST_SLIP_CHK) ? (r_match && w_word_ok) : 1'b1;

            if (r_state == ST_SLIP_CHK && w_state_nxt == ST_DONE)
                r_tap_out <= r_tap;
        end
    end

    // Reference word for the stability check; pure data, no reset needed.
    always_ff @(posedge clk_i) begin
        if (r_state == ST_CHECK && r_cnt == 8'd0)
            r_first_word <= data_i;
    end

    assign dl_ce_o     = 1'b0;
    assign dl_in_o     = 1'b0;
    assign dl_cnt_in_o = r_tap;
    assign fail_code_o = r_fail_code;
    assign tap_o       = r_tap_out;
    assign eye_width_o = w_best_len;

endmodule
